// File: rtl/lif_pkg.sv
// lif_pkg: default widths shared by the LIF readout blocks plus a saturating increment
package lif_pkg;
    localparam int RATE_CNT_W    = 8;
    localparam int ISI_W         = 12;
    localparam int WINDOW_CYCLES = 64;

    // v + inc, clamped at 2^w - 1
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc, input int w);
        logic [31:0] mx;
        mx = (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        return (inc && v < mx) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/spike_rate_meter_if.sv
// spike_rate_meter_if: {rate, ISI} record channel with valid/ready handshake and overrun flag
interface spike_rate_meter_if import lif_pkg::*; #(
    parameter int CNT_W = RATE_CNT_W,
    parameter int ISI_W = lif_pkg::ISI_W
);
    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    modport master (output rate_out, isi_out, out_valid, overrun, input out_ready);
    modport slave  (input rate_out, isi_out, out_valid, overrun, output out_ready);
endinterface

// File: rtl/spike_edge_detect.sv
// spike_edge_detect: rising-edge pulse from a spike level; SPIKE_RATE_SYNC_EN adds a 2-flop synchronizer
module spike_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic evt_o
);
    logic src;
    logic spike_q;
`ifdef SPIKE_RATE_SYNC_EN
    logic [1:0] sync_q;
    // two-flop synchronizer for an asynchronous spike source
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], sig_i};
    assign src = sync_q[1];
`else
    assign src = sig_i;
`endif
    // previous level, so a long high level yields a single event
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) spike_q <= 1'b0;
        else        spike_q <= src;
    assign evt_o = src & ~spike_q;
endmodule

// File: rtl/spike_rate_meter.sv
// spike_rate_meter: per-window spike count and last inter-spike interval, one record per window
// Optional macro SPIKE_RATE_SYNC_EN synchronizes spike_in before edge detection.
module spike_rate_meter import lif_pkg::*; #(
    parameter int WINDOW_CYCLES = lif_pkg::WINDOW_CYCLES,
    parameter int CNT_W         = RATE_CNT_W,
    parameter int ISI_W         = lif_pkg::ISI_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spike_in,
    spike_rate_meter_if.master        bus
);
    localparam int WIN_W = $clog2(WINDOW_CYCLES);

    logic             evt, close, xfer;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d, cnt_inc, rate_q, rate_d;
    logic [ISI_W-1:0] timer_q, timer_d, timer_inc, last_isi_q, last_isi_d, isi_q, isi_d;
    logic             have_prev_q, have_prev_d, valid_q, valid_d, overrun_q, overrun_d;

    spike_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (spike_in),
        .evt_o (evt)
    );

    // window counting, ISI timing and record/handshake next state
    always_comb begin
        close       = win_cnt_q == WIN_W'(WINDOW_CYCLES - 1);
        xfer        = valid_q & bus.out_ready;
        win_cnt_d   = close ? '0 : win_cnt_q + WIN_W'(1);
        cnt_inc     = CNT_W'(sat_inc(32'(spike_cnt_q), evt, CNT_W));
        spike_cnt_d = close ? '0 : cnt_inc;
        timer_inc   = ISI_W'(sat_inc(32'(timer_q), 1'b1, ISI_W));
        timer_d     = evt ? '0 : timer_inc;
        last_isi_d  = (evt && have_prev_q) ? timer_inc : last_isi_q;
        have_prev_d = have_prev_q | evt;
        rate_d      = close ? cnt_inc : rate_q;
        isi_d       = close ? last_isi_d : isi_q;
        valid_d     = close | (valid_q & ~xfer);
        overrun_d   = overrun_q | (close & valid_q & ~xfer);
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            win_cnt_q   <= '0;
            spike_cnt_q <= '0;
            timer_q     <= '0;
            last_isi_q  <= '0;
            have_prev_q <= 1'b0;
            rate_q      <= '0;
            isi_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            spike_cnt_q <= spike_cnt_d;
            timer_q     <= timer_d;
            last_isi_q  <= last_isi_d;
            have_prev_q <= have_prev_d;
            rate_q      <= rate_d;
            isi_q       <= isi_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end

    assign bus.rate_out  = rate_q;
    assign bus.isi_out   = isi_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_spike_rate_meter.sv
// tb_spike_rate_meter: directed vectors for spike_rate_meter (default widths and a 3-bit count instance)
module tb_spike_rate_meter;
    localparam int W = 64;
`ifdef SPIKE_RATE_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spike_in = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    spike_rate_meter_if #(.CNT_W(8), .ISI_W(12)) bus ();
    spike_rate_meter_if #(.CNT_W(3), .ISI_W(12)) bus2 ();

    spike_rate_meter #(.WINDOW_CYCLES(W), .CNT_W(8), .ISI_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .bus(bus));
    spike_rate_meter #(.WINDOW_CYCLES(W), .CNT_W(3), .ISI_W(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .bus(bus2));

    always #5 clk = ~clk;

    typedef struct {
        int st, per, wid, n;
        int rate, isi, rate2;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ready(input logic r);
        bus.out_ready  = r;
        bus2.out_ready = r;
    endtask

    // drives window cycles first..W-1 and returns #1 after the closing edge
    task automatic run_window(input int first, input int st, input int per, input int wid, input int n,
                              input logic ra, input logic rb, input logic rc, input bit idle_chk);
        for (int c = first; c < W; c++) begin
            spike_in = (n > 0 && c >= st && ((c - st) % per) < wid && ((c - st) / per) < n);
            set_ready((c == 0) ? ra : (c == W - 1) ? rc : rb);
            @(posedge clk);
            #1;
            if (idle_chk && c == W - 2) chk("idle_valid", 32'(bus.out_valid), 0);
        end
        spike_in = 1'b0;
    endtask

    task automatic chk_rec(input string name, input int v, input int r, input int i, input int ov);
        chk({name, "_valid"}, 32'(bus.out_valid), v);
        chk({name, "_rate"}, 32'(bus.rate_out), r);
        if (i >= 0) chk({name, "_isi"}, 32'(bus.isi_out), i);
        chk({name, "_overrun"}, 32'(bus.overrun), ov);
    endtask

    initial begin
        tbl[0] = '{st: 3,  per: 8,  wid: 1,  n: 8,  rate: 8,  isi: 8,   rate2: 7};
        tbl[1] = '{st: 2,  per: 20, wid: 5,  n: 2,  rate: 2,  isi: 20,  rate2: 2};
        tbl[2] = '{st: 1,  per: 3,  wid: 1,  n: 20, rate: 20, isi: 3,   rate2: 7};
        tbl[3] = '{st: 10, per: 64, wid: 1,  n: 1,  rate: 1,  isi: 16,  rate2: 1};
        tbl[4] = '{st: 0,  per: 1,  wid: 1,  n: 0,  rate: 0,  isi: 16,  rate2: 0};
        tbl[5] = '{st: 4,  per: 64, wid: 30, n: 1,  rate: 1,  isi: 122, rate2: 1};
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_rec("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        foreach (tbl[k]) begin
            run_window(0, tbl[k].st, tbl[k].per, tbl[k].wid, tbl[k].n, 1'b1, 1'b1, 1'b1, 1'b1);
            chk_rec($sformatf("vec%0d", k), 1, tbl[k].rate, tbl[k].isi, 0);
            chk($sformatf("vec%0d_rate2", k), 32'(bus2.rate_out), tbl[k].rate2);
        end
        // ready only on the closing edge: old record leaves, new one loads, no overrun
        run_window(0, 10, 7, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_rec("close_xfer", 1, 2, 7, 0);
        // reset in the middle of a window
        set_ready(1'b1);
        for (int c = 0; c < 30; c++) begin
            spike_in = (c == 5 || c == 15);
            @(posedge clk);
            #1;
        end
        spike_in = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_rec("async_rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_window(0, 20, 9, 1, 3, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rec("post_rst", 1, 3, 9, 0);
        // two closes without a transfer
        run_window(0, 5, 10, 1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_rec("ovr_a", 1, 3, 10, 0);
        run_window(0, 5, 10, 1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_rec("ovr_b", 1, 5, 10, 1);
        set_ready(1'b1);
        @(posedge clk);
        #1 chk_rec("ovr_xfer", 0, 5, 10, 1);
        run_window(1, 0, 1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rec("ovr_next", 1, 0, 10, 1);
        // ISI saturation over a gap of 66 windows
        run_window(0, 5, 64, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (65) run_window(0, 0, 1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_window(0, 5, 64, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rec("isi_sat", 1, 1, 4095, 1);
        chk("isi_sat_rate2", 32'(bus2.rate_out), 1);
        // pulse two cycles before close: lands in the next window when synchronized
        run_window(0, W - 2, 64, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rec("late_cur", 1, SYNC ? 0 : 1, -1, 1);
        run_window(0, 0, 1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rec("late_next", 1, SYNC ? 1 : 0, -1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
